if2_id_queue: RTL and testbench

Parametrised IF2→ID decoupling queue that replaces the single-entry IF2/ID register with a DEPTH-entry FIFO using valid/ready handshakes on both sides. It sits between fetch stage 2 and decode. Each entry carries PC, instruction, fetch exception, cache-hit flag, branch prediction and a META_W-bit predictor metadata field. Fetch stalls are absorbed by buffering instead of a side replay buffer.

---
 rtl/if2_id_queue_pkg.sv | 22 ++
 rtl/if2_id_queue_mem.sv | 25 ++
 rtl/if2_id_queue.sv | 93 +++++++++
 tb/tb_if2_id_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if2_id_queue_pkg.sv
// Entry layout shared by the IF2->ID queue and its storage array.
// The first 68 bits are fixed fields; predictor metadata sits on top.
package if2_id_queue_pkg;

   localparam int META_W_DFLT     = 2;
   localparam int IF_ENTRY_BASE_W = 32 + 32 + 1 + 1 + 1 + 1;

   localparam int OFF_PC      = 0;
   localparam int OFF_INST    = 32;
   localparam int OFF_ADEF    = 64;
   localparam int OFF_HIT     = 65;
   localparam int OFF_BP      = 66;
   localparam int OFF_FLUSHED = 67;
   localparam int OFF_META    = 68;

   function automatic int if_entry_w(input int meta_w);
      return IF_ENTRY_BASE_W + meta_w;
   endfunction

   localparam int IF_ENTRY_W = IF_ENTRY_BASE_W + META_W_DFLT;

endpackage

// File: rtl/if2_id_queue_mem.sv
// DEPTH x W entry storage: one synchronous write port, one asynchronous read port.
// Data carries no reset; the queue gates everything it reads with out_valid.
module if2_id_queue_mem
   import if2_id_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = IF_ENTRY_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if2_id_queue.sv
// IF2->ID decoupling FIFO with valid/ready on both sides; replaces the single
// IF2/ID register so fetch stalls are absorbed by buffering.
module if2_id_queue
   import if2_id_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int META_W = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_inst,
   input  logic                       in_inst_valid,
   input  logic                       in_adef,
   input  logic                       in_hit,
   input  logic                       in_branch_bp,
   input  logic [META_W-1:0]          in_meta,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_inst,
   output logic                       out_adef,
   output logic                       out_hit,
   output logic                       out_branch_bp,
   output logic [META_W-1:0]          out_meta,
   output logic                       out_flushed,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = if_entry_w(META_W);

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          pend_flush;
   logic          enq, deq;
   logic [EW-1:0] wr_entry, rd_entry;

   // in_ready looks only at registered occupancy, never at out_ready.
   assign in_ready  = rst_n && (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;

   always_comb begin
      wr_entry                      = '0;
      wr_entry[OFF_PC +: 32]        = in_pc;
      wr_entry[OFF_INST +: 32]      = in_inst_valid ? in_inst : 32'h0;
      wr_entry[OFF_ADEF]            = in_adef;
      wr_entry[OFF_HIT]             = in_inst_valid & in_hit;
      wr_entry[OFF_BP]              = in_branch_bp;
      wr_entry[OFF_FLUSHED]         = pend_flush;
      wr_entry[OFF_META +: META_W]  = in_meta;
   end

   // Flush and reset share one path; any same-cycle handshake is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pend_flush <= 1'b1;
      end else begin
         if (enq) begin
            wr_ptr     <= wr_ptr + 1'b1;
            pend_flush <= 1'b0;
         end
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(enq) - CW'(deq);
      end
   end

   if2_id_queue_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
      .clk   (clk),
      .we    (enq && !flush),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   assign out_pc        = out_valid ? rd_entry[OFF_PC +: 32]       : '0;
   assign out_inst      = out_valid ? rd_entry[OFF_INST +: 32]     : '0;
   assign out_adef      = out_valid & rd_entry[OFF_ADEF];
   assign out_hit       = out_valid & rd_entry[OFF_HIT];
   assign out_branch_bp = out_valid & rd_entry[OFF_BP];
   assign out_flushed   = out_valid & rd_entry[OFF_FLUSHED];
   assign out_meta      = out_valid ? rd_entry[OFF_META +: META_W] : '0;

endmodule

// File: tb/tb_if2_id_queue.sv
// Bench for if2_id_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the FIFO rules.
module tb_if2_id_queue;

   localparam int DEPTH  = 4;
   localparam int META_W = 2;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int VW     = 1 + 32 + 32 + 1 + 1 + 1 + META_W + 1 + CW + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_pc = '0;
   logic [31:0]       in_inst = '0;
   logic              in_inst_valid = 1'b0;
   logic              in_adef = 1'b0;
   logic              in_hit = 1'b0;
   logic              in_branch_bp = 1'b0;
   logic [META_W-1:0] in_meta = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_pc, out_inst;
   logic              out_adef, out_hit, out_branch_bp, out_flushed;
   logic [META_W-1:0] out_meta;
   logic [CW-1:0]     count;

   if2_id_queue #(.DEPTH(DEPTH), .META_W(META_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_inst_valid(in_inst_valid),
      .in_adef(in_adef), .in_hit(in_hit), .in_branch_bp(in_branch_bp), .in_meta(in_meta),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_adef(out_adef), .out_hit(out_hit),
      .out_branch_bp(out_branch_bp), .out_meta(out_meta), .out_flushed(out_flushed),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       pc;
      logic [31:0]       inst;
      logic              adef;
      logic              hit;
      logic              bp;
      logic [META_W-1:0] meta;
      logic              flushed;
   } entry_t;

   entry_t q[$];
   logic   m_pend = 1'b1;
   int     n_checks = 0;
   int     n_pass = 0;

   wire [VW-1:0] act_vec = {out_valid, out_pc, out_inst, out_adef, out_hit,
                            out_branch_bp, out_meta, out_flushed, count, in_ready};

   // Model: what ID should see after the edge, from the queue contents.
   function automatic logic [VW-1:0] exp_vec();
      logic [VW-1:0] v;
      logic          rdy;
      rdy = rst_n && (q.size() < DEPTH);
      if (q.size() == 0)
         v = {1'b0, 32'h0, 32'h0, 3'b000, {META_W{1'b0}}, 1'b0, CW'(0), rdy};
      else
         v = {1'b1, q[0].pc, q[0].inst, q[0].adef, q[0].hit, q[0].bp, q[0].meta,
              q[0].flushed, CW'(q.size()), rdy};
      return v;
   endfunction

   // Advance one clock; the model consumes the inputs as they stand at the edge.
   task automatic tick();
      entry_t e;
      bit     acc_in, acc_out;
      @(posedge clk);
      if (!rst_n || flush) begin
         q.delete();
         m_pend = 1'b1;
      end else begin
         acc_in  = in_valid && (q.size() < DEPTH);
         acc_out = out_ready && (q.size() != 0);
         if (acc_out) void'(q.pop_front());
         if (acc_in) begin
            e.pc      = in_pc;
            e.inst    = in_inst_valid ? in_inst : 32'h0;
            e.adef    = in_adef;
            e.hit     = in_inst_valid && in_hit;
            e.bp      = in_branch_bp;
            e.meta    = in_meta;
            e.flushed = m_pend;
            q.push_back(e);
            m_pend = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic iv, input logic adef, input logic hit,
                        input logic bp, input logic [META_W-1:0] meta);
      in_valid = v; in_pc = pc; in_inst = inst; in_inst_valid = iv;
      in_adef = adef; in_hit = hit; in_branch_bp = bp; in_meta = meta;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 32'h1234_5678, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
      tick(); tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== '0)
         $display("FAIL reset_state: ready=%b valid=%b count=%0d required 0/0/0", in_ready, out_valid, count);
      else n_pass++;
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || act_vec !== exp_vec())
         $display("FAIL reset_release: got %h required %h", act_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_first_enqueue();
      drive(1'b1, 32'h1c00_0000, 32'h0280_0c0c, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0000 || out_inst !== 32'h0280_0c0c ||
          out_flushed !== 1'b1 || count !== CW'(1))
         $display("FAIL first_enqueue: valid=%b pc=%h inst=%h fl=%b count=%0d required 1/1c000000/02800c0c/1/1",
                  out_valid, out_pc, out_inst, out_flushed, count);
      else n_pass++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || count !== '0)
         $display("FAIL first_drain: valid=%b count=%0d required 0/0", out_valid, count);
      else n_pass++;
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(1'b1, 32'h2000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b1, 1'(i), 2'(i));
         tick();
      end
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (count !== CW'(DEPTH) || in_ready !== 1'b0 || act_vec !== exp_vec())
         $display("FAIL fill_full: count=%0d ready=%b required %0d/0", count, in_ready, DEPTH);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (out_pc !== 32'h2000_0000 + 32'(i * 4))
            $display("FAIL drain_order%0d: pc=%h required %h", i, out_pc, 32'h2000_0000 + 32'(i * 4));
         else n_pass++;
         tick();
      end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || count !== '0 || act_vec !== exp_vec())
         $display("FAIL drain_empty: got %h required %h", act_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_full_stream();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h3000_0000 + 32'(i * 4), 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
         tick();
      end
      out_ready = 1'b1;
      for (int i = DEPTH; i < DEPTH + 8; i++) begin
         drive(1'b1, 32'h3000_0000 + 32'(i * 4), 32'(i), 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
         tick();
         n_checks++;
         if (act_vec !== exp_vec())
            $display("FAIL full_stream%0d: got %h required %h", i, act_vec, exp_vec());
         else n_pass++;
      end
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH + 1; i++) tick();
      out_ready = 1'b0;
   endtask

   task automatic test_inst_invalid();
      drive(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_inst !== 32'h0 || out_hit !== 1'b0 || out_meta !== 2'b11 ||
          out_adef !== 1'b1 || out_branch_bp !== 1'b1 || out_pc !== 32'h4000_0010)
         $display("FAIL inst_invalid: inst=%h hit=%b meta=%b adef=%b bp=%b required 0/0/11/1/1",
                  out_inst, out_hit, out_meta, out_adef, out_branch_bp);
      else n_pass++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h5000_0000 + 32'(i * 4), 32'(i), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
         tick();
      end
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (count !== '0 || out_valid !== 1'b0 || act_vec !== exp_vec())
         $display("FAIL flush_clear: count=%0d valid=%b required 0/0", count, out_valid);
      else n_pass++;
      drive(1'b1, 32'h6000_0000, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
      tick();
      drive(1'b1, 32'h6000_0004, 32'h22, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_flushed !== 1'b1 || out_pc !== 32'h6000_0000)
         $display("FAIL flush_first: flushed=%b pc=%h required 1/60000000", out_flushed, out_pc);
      else n_pass++;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_flushed !== 1'b0 || out_pc !== 32'h6000_0004)
         $display("FAIL flush_second: flushed=%b pc=%h required 0/60000004", out_flushed, out_pc);
      else n_pass++;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h7000_0000 + 32'(i * 4), 32'hFFFF_0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
         tick();
      end
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (act_vec !== {VW{1'b0}})
         $display("FAIL reset_mid: got %h required all zero", act_vec);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(63) != 0);
         flush = ($urandom_range(15) == 0);
         out_ready = ($urandom_range(2) != 0);
         drive(1'($urandom_range(3) != 0), $urandom, $urandom, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
         tick();
         n_checks++;
         if (act_vec !== exp_vec())
            $display("FAIL random%0d: got %h required %h", c, act_vec, exp_vec());
         else n_pass++;
      end
      rst_n = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_first_enqueue();
      test_fill_drain();
      test_full_stream();
      test_inst_invalid();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
